// File: rtl/bgr_startup_seq.sv
// -----------------------------------------------------------------------------
// bgr_startup_seq
//
// Start-up sequencer for the user-area bandgap reference. It drives the BGR
// enable and reset, then waits for the BGR to settle. It debounces the
// comparator "output OK" flag and retries failed attempts before latching a
// sticky fault. The result is a single clean ready flag plus status.
//
// Ports
//   wb_clk_i     in   system clock
//   wb_rst_i     in   synchronous active-high reset
//   start_i      in   level enable; low forces IDLE and clears the retry count
//   porst_i      in   asynchronous pad re-arm pulse (2-flop synchronized)
//   cmp_ok_i     in   asynchronous BGR-in-range flag (2-flop synchronized)
//   bgr_en_o     out  BGR enable
//   bgr_rst_o    out  BGR reset / start-up kick
//   ready_o      out  BGR verified stable
//   fault_o      out  sticky failure flag
//   state_o      out  current state encoding (debug view of the FSM)
//   retry_cnt_o  out  failed attempts in the current run
//
// Signal semantics: there is no valid/ready handshake on this block. start_i
// is a level qualifier. porst_i acts only on its synchronized rising edge. All
// outputs are flops and change on the same clock edge as the state.
// -----------------------------------------------------------------------------
module bgr_startup_seq #(
    parameter int RST_CYCLES    = 8,
    parameter int SETTLE_CYCLES = 4000,
    parameter int DEBOUNCE      = 16,
    parameter int CHECK_TIMEOUT = 2000,
    parameter int RETRY_MAX     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       start_i,
    input  logic       porst_i,
    input  logic       cmp_ok_i,
    output logic       bgr_en_o,
    output logic       bgr_rst_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_READY  = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(CHECK_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;   // phase counter / debounce / loss counter
    logic [CNT_W-1:0] tmo, tmo_nxt;   // CHECK timeout counter
    logic [1:0]       retry, retry_nxt;

    logic cmp_meta, cmp_s;
    logic por_meta, por_s, por_d;
    logic por_rise;

    // One-cycle pulse on the synchronized rising edge. A held-high pad
    // therefore re-arms the sequence only once.
    assign por_rise    = por_s & ~por_d;
    assign state_o     = state;
    assign retry_cnt_o = retry;

    // Counters move one step per cycle. A transition fires on the edge where
    // the counter would reach its limit, so each phase lasts exactly that
    // many cycles and the counters never wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmo_nxt   = tmo;
        retry_nxt = retry;
        if (!start_i) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            tmo_nxt   = '0;
            retry_nxt = '0;
        end else if (por_rise) begin
            state_nxt = ST_RESET;
            cnt_nxt   = '0;
            tmo_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = '0;
                    tmo_nxt   = '0;
                end
                ST_RESET: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = ST_SETTLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state_nxt = ST_CHECK;
                        cnt_nxt   = '0;
                        tmo_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    // Acceptance is tested first so it wins over a
                    // coincident timeout.
                    if (cmp_s && (cnt == DEB_LAST)) begin
                        state_nxt = ST_READY;
                        cnt_nxt   = '0;
                        tmo_nxt   = '0;
                        retry_nxt = '0;
                    end else if (tmo == TMO_LAST) begin
                        cnt_nxt   = '0;
                        tmo_nxt   = '0;
                        retry_nxt = (retry == 2'd3) ? retry : retry + 2'd1;
                        state_nxt = (int'(retry) < RETRY_MAX - 1) ? ST_RESET : ST_FAULT;
                    end else begin
                        cnt_nxt = cmp_s ? cnt + CNT_W'(1) : '0;
                        tmo_nxt = tmo + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (!cmp_s && (cnt == DEB_LAST)) begin
                        state_nxt = ST_RESET;
                        cnt_nxt   = '0;
                        retry_nxt = (retry == 2'd3) ? retry : retry + 2'd1;
                    end else begin
                        cnt_nxt = cmp_s ? '0 : cnt + CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    // Sticky: only reset, start_i low or a pad re-arm leave.
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    tmo_nxt   = '0;
                    retry_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tmo       <= '0;
            retry     <= '0;
            cmp_meta  <= 1'b0;
            cmp_s     <= 1'b0;
            por_meta  <= 1'b0;
            por_s     <= 1'b0;
            por_d     <= 1'b0;
            bgr_en_o  <= 1'b0;
            bgr_rst_o <= 1'b1;
            ready_o   <= 1'b0;
            fault_o   <= 1'b0;
        end else begin
            cmp_meta  <= cmp_ok_i;
            cmp_s     <= cmp_meta;
            por_meta  <= porst_i;
            por_s     <= por_meta;
            por_d     <= por_s;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tmo       <= tmo_nxt;
            retry     <= retry_nxt;
            bgr_en_o  <= (state_nxt == ST_RESET) || (state_nxt == ST_SETTLE) ||
                         (state_nxt == ST_CHECK) || (state_nxt == ST_READY);
            bgr_rst_o <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET) ||
                         (state_nxt == ST_FAULT);
            ready_o   <= (state_nxt == ST_READY);
            fault_o   <= (state_nxt == ST_FAULT);
        end
    end

endmodule
